tlb_refill_walker: RTL and testbench
====================================

TLB_REFILL_WALKER -- requirements
Module: tlb_refill_walker

Interface
REQ-001 SHALL have parameter LOG_WAYS, default 2, giving log2 of the number of TLB ways (4).
REQ-002 SHALL have parameter VPN_W, default 22, giving the virtual page number width.
REQ-003 SHALL have parameter PFN_W, default 22, giving the physical frame number width.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port MISS_REQ, input, 1 bit: a translation miss requests a refill.
REQ-007 SHALL have port MISS_VPN, input, VPN_W bits: VPN of the missing page.
REQ-008 SHALL have port ASID, input, 8 bits: current address-space ID.
REQ-009 SHALL have port PTBR, input, 32 bits: page-table base byte address.
REQ-010 SHALL have port ABORT, input, 1 bit: pipeline flush; cancels the walk.
REQ-011 SHALL have port MEM_RD, output, 1 bit: PTE read request.
REQ-012 SHALL have port MEM_ADDR, output, 32 bits: PTE byte address.
REQ-013 SHALL have port MEM_RDY, input, 1 bit: read data valid.
REQ-014 SHALL have port MEM_RDATA, input, 32 bits: PTE word.
REQ-015 SHALL have port TLB_INDEX, output, LOG_WAYS bits: victim way.
REQ-016 SHALL have port TLB_ENTRY, output, VPN_W+PFN_W+10 bits: entry to write.
REQ-017 SHALL have port TLB_WE, output, 1 bit: TLB write strobe.
REQ-018 SHALL have port BUSY, output, 1 bit: walker not in IDLE.
REQ-019 SHALL have port DONE, output, 1 bit: one-cycle pulse, refill complete.
REQ-020 SHALL have port FAULT, output, 1 bit: one-cycle pulse, PTE invalid.

Function
REQ-021 SHALL use the FSM states IDLE, READ, FILL, FAULT; BUSY SHALL be 1 in every state except IDLE.
REQ-022 In IDLE, MISS_REQ=1 with ABORT=0 SHALL latch MISS_VPN and ASID and go to READ on the next edge; MISS_REQ SHALL be ignored in every other state.
REQ-023 In READ, MEM_RD SHALL be 1 and MEM_ADDR SHALL be PTBR + {zero-extended latched VPN, 2'b00}, modulo 2^32; MEM_RD SHALL stay high until MEM_RDY is sampled 1.
REQ-024 On MEM_RDY=1 in READ, the walker SHALL go to FILL if MEM_RDATA[0] (V) is 1, else to FAULT.
REQ-025 TLB_ENTRY SHALL be {VPN[VPN_W-1:0], ASID[7:0], PFN=MEM_RDATA[31:10], D=MEM_RDATA[1], V=1}, registered when MEM_RDY is accepted.
REQ-026 In FILL, TLB_WE=1 and DONE=1 for exactly one cycle, TLB_INDEX SHALL equal the victim counter, and the next state SHALL be IDLE.
REQ-027 The victim counter SHALL advance by 1 after each FILL and wrap from 2^LOG_WAYS-1 to 0.
REQ-028 In FAULT, FAULT=1 for one cycle, with no TLB write and no counter change; the next state SHALL be IDLE.
REQ-029 A clean PTE (D=0) SHALL still be installed, including for write misses.
REQ-030 ABORT=1 in READ SHALL return the walker to IDLE on the next edge, with no write and no pulse; ABORT SHALL take priority over a simultaneous MEM_RDY.
REQ-031 ABORT=1 in FILL or FAULT SHALL NOT suppress that cycle's outputs.
REQ-032 TLB_WE, DONE, FAULT and MEM_RD SHALL be 0 whenever not explicitly asserted above.
REQ-033 Refill latency SHALL be: MISS_REQ at cycle N, MEM_RD from N+1, MEM_RDY at M, TLB_WE/DONE at M+1.

Reset
REQ-034 RESET=1 SHALL immediately force IDLE, victim counter = 0 (1 with WALKER_WIRED_EN), latched VPN/ASID/entry = 0, and all outputs 0.
REQ-035 RESET mid-walk SHALL abandon the walk; a later MEM_RDY SHALL be ignored while in IDLE.

Configuration
REQ-036 Macro WALKER_WIRED_EN, when defined, SHALL reserve way 0: the counter SHALL cycle 1..2^LOG_WAYS-1, wrap to 1, and never output TLB_INDEX=0.
REQ-037 Without WALKER_WIRED_EN, all ways 0..2^LOG_WAYS-1 SHALL be victims.

Verification
REQ-038 PTBR=0x0010_0000, MISS_VPN=0x00003, ASID=0x05, MEM_RDATA=0x0000_8C03 after 2 wait cycles -> MEM_ADDR=0x0010_000C; TLB_WE pulse with VPN=0x00003, ASID=0x05, PFN=0x00023, D=1, V=1, index 0; DONE pulse.
REQ-039 Five consecutive valid refills -> TLB_INDEX 0,1,2,3,0 (1,2,3,1,2 with WALKER_WIRED_EN).
REQ-040 MEM_RDATA=0x0000_8C02 (V=0) -> one FAULT pulse, no TLB_WE, next refill still uses the prior index.
REQ-041 ABORT asserted in the same cycle as MEM_RDY -> IDLE, no TLB_WE/DONE/FAULT, BUSY=0 next cycle.
REQ-042 RESET pulsed during READ, then stray MEM_RDY -> all outputs 0, no write, counter at reset value.
REQ-043 MISS_REQ held high throughout a walk -> exactly one refill per return to IDLE; a new walk starts the cycle after DONE.

Source files
------------

// File: rtl/tlb_refill_walker.sv
// tlb_refill_walker: single-level TLB refill engine.
// On a miss it reads one PTE at PTBR + VPN*4 and either installs it into the
// victim way (FILL) or reports an invalid PTE (FAULT).
// Optional feature macro: WALKER_WIRED_EN reserves way 0, so victims cycle
// 1..2^LOG_WAYS-1 and way 0 is never selected.
//
// Handshake: MEM_RD is held high in READ until MEM_RDY is sampled high on a
// rising edge; that edge accepts MEM_RDATA. ABORT in READ wins over MEM_RDY.
module tlb_refill_walker #(
    parameter int LOG_WAYS = 2,
    parameter int VPN_W    = 22,
    parameter int PFN_W    = 22
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      MISS_REQ,
    input  logic [VPN_W-1:0]          MISS_VPN,
    input  logic [7:0]                ASID,
    input  logic [31:0]               PTBR,
    input  logic                      ABORT,
    output logic                      MEM_RD,
    output logic [31:0]               MEM_ADDR,
    input  logic                      MEM_RDY,
    input  logic [31:0]               MEM_RDATA,
    output logic [LOG_WAYS-1:0]       TLB_INDEX,
    output logic [VPN_W+PFN_W+9:0]    TLB_ENTRY,
    output logic                      TLB_WE,
    output logic                      BUSY,
    output logic                      DONE,
    output logic                      FAULT,
    output logic [1:0]                dbg_state_o
);

    localparam int ENTRY_W = VPN_W + PFN_W + 10;
    localparam logic [LOG_WAYS-1:0] WAY_MAX = '1;
`ifdef WALKER_WIRED_EN
    localparam logic [LOG_WAYS-1:0] WAY_FIRST = LOG_WAYS'(1);
`else
    localparam logic [LOG_WAYS-1:0] WAY_FIRST = '0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_FILL  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [VPN_W-1:0]     vpn_q, vpn_d;
    logic [7:0]           asid_q, asid_d;
    logic [ENTRY_W-1:0]   entry_q, entry_d;
    logic [LOG_WAYS-1:0]  victim_q, victim_d;
    logic [31:0]          pte_off;

    // Byte offset of the PTE: VPN scaled by 4, wrapped to 32 bits.
    assign pte_off = 32'({vpn_q, 2'b00});

    // State and datapath registers; reset abandons any walk in flight.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            vpn_q    <= '0;
            asid_q   <= '0;
            entry_q  <= '0;
            victim_q <= WAY_FIRST;
        end else begin
            state_q  <= state_d;
            vpn_q    <= vpn_d;
            asid_q   <= asid_d;
            entry_q  <= entry_d;
            victim_q <= victim_d;
        end
    end

    // Next-state, latching decisions and per-state output strobes.
    always_comb begin
        state_d  = state_q;
        vpn_d    = vpn_q;
        asid_d   = asid_q;
        entry_d  = entry_q;
        victim_d = victim_q;
        MEM_RD   = 1'b0;
        MEM_ADDR = '0;
        TLB_WE   = 1'b0;
        DONE     = 1'b0;
        FAULT    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (MISS_REQ && !ABORT) begin
                    vpn_d   = MISS_VPN;
                    asid_d  = ASID;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                MEM_RD   = 1'b1;
                MEM_ADDR = PTBR + pte_off;
                if (ABORT) begin
                    state_d = ST_IDLE;
                end else if (MEM_RDY) begin
                    // Dirty bit is copied as-is; a clean PTE is still installed.
                    entry_d = {vpn_q, asid_q, PFN_W'(MEM_RDATA[31:10]),
                               MEM_RDATA[1], 1'b1};
                    state_d = MEM_RDATA[0] ? ST_FILL : ST_FAULT;
                end
            end
            ST_FILL: begin
                TLB_WE   = 1'b1;
                DONE     = 1'b1;
                victim_d = (victim_q == WAY_MAX) ? WAY_FIRST
                                                 : victim_q + LOG_WAYS'(1);
                state_d  = ST_IDLE;
            end
            ST_FAULT: begin
                FAULT   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign BUSY        = (state_q != ST_IDLE);
    assign TLB_INDEX   = victim_q;
    assign TLB_ENTRY   = entry_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_tlb_refill_walker.sv
// tb_tlb_refill_walker: randomized self-checking bench for tlb_refill_walker.
// Reference model: PTE address is PTBR + VPN*4, entries follow the field
// packing rule, and victims walk through a list of allowed ways.
module tb_tlb_refill_walker;

    localparam int LOG_WAYS = 2;
    localparam int VPN_W    = 22;
    localparam int PFN_W    = 22;
    localparam int ENTRY_W  = VPN_W + PFN_W + 10;

    logic                 CLK;
    logic                 RESET;
    logic                 MISS_REQ;
    logic [VPN_W-1:0]     MISS_VPN;
    logic [7:0]           ASID;
    logic [31:0]          PTBR;
    logic                 ABORT;
    logic                 MEM_RD;
    logic [31:0]          MEM_ADDR;
    logic                 MEM_RDY;
    logic [31:0]          MEM_RDATA;
    logic [LOG_WAYS-1:0]  TLB_INDEX;
    logic [ENTRY_W-1:0]   TLB_ENTRY;
    logic                 TLB_WE;
    logic                 BUSY;
    logic                 DONE;
    logic                 FAULT;
    logic [1:0]           dbg_state;

    int checks = 0;
    int errors = 0;

    // Reference model: allowed victim ways in order, and a pointer into them.
    int ways[$];
    int way_ptr;
    logic [ENTRY_W-1:0] exp_q[$];

    tlb_refill_walker #(
        .LOG_WAYS(LOG_WAYS),
        .VPN_W   (VPN_W),
        .PFN_W   (PFN_W)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .MISS_REQ   (MISS_REQ),
        .MISS_VPN   (MISS_VPN),
        .ASID       (ASID),
        .PTBR       (PTBR),
        .ABORT      (ABORT),
        .MEM_RD     (MEM_RD),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_RDY    (MEM_RDY),
        .MEM_RDATA  (MEM_RDATA),
        .TLB_INDEX  (TLB_INDEX),
        .TLB_ENTRY  (TLB_ENTRY),
        .TLB_WE     (TLB_WE),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .FAULT      (FAULT),
        .dbg_state_o(dbg_state)
    );

    // Clock generation.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Driver: one full walk starting from IDLE at #1 after a rising edge.
    // Returns the observations; callers do the comparisons.
    task automatic do_walk(
        input  logic [VPN_W-1:0]    vpn,
        input  logic [7:0]          asid,
        input  logic [31:0]         rdata,
        input  int                  wait_n,
        input  logic                abort_rdy,
        input  logic                abort_fill,
        output logic                rd_ok,
        output logic [31:0]         addr_seen,
        output logic                addr_stable,
        output logic                we_o,
        output logic                done_o,
        output logic                fault_o,
        output logic                busy_o,
        output logic [LOG_WAYS-1:0] index_o,
        output logic [ENTRY_W-1:0]  entry_o,
        output logic                busy_after,
        output logic                pulse_after
    );
        MISS_REQ = 1'b1;
        MISS_VPN = vpn;
        ASID     = asid;
        @(posedge CLK); #1;
        MISS_REQ = 1'b0;
        MISS_VPN = VPN_W'($urandom);
        ASID     = 8'($urandom);
        rd_ok       = MEM_RD && BUSY && !TLB_WE && !DONE && !FAULT;
        addr_seen   = MEM_ADDR;
        addr_stable = 1'b1;
        for (int w = 0; w < wait_n; w++) begin
            @(posedge CLK); #1;
            rd_ok = rd_ok && MEM_RD && BUSY && !TLB_WE && !DONE && !FAULT;
            if (MEM_ADDR !== addr_seen) addr_stable = 1'b0;
        end
        MEM_RDY   = 1'b1;
        MEM_RDATA = rdata;
        ABORT     = abort_rdy;
        @(posedge CLK); #1;
        MEM_RDY   = 1'b0;
        MEM_RDATA = $urandom;
        ABORT     = abort_fill;
        #1;
        we_o    = TLB_WE;
        done_o  = DONE;
        fault_o = FAULT;
        busy_o  = BUSY;
        index_o = TLB_INDEX;
        entry_o = TLB_ENTRY;
        @(posedge CLK); #1;
        ABORT       = 1'b0;
        busy_after  = BUSY;
        pulse_after = TLB_WE | DONE | FAULT | MEM_RD;
    endtask

    // Driver: pulse reset and resynchronise the model.
    task automatic pulse_reset();
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        way_ptr = 0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        MISS_REQ = 1'b0; MISS_VPN = '0; ASID = '0; PTBR = '0;
        ABORT = 1'b0; MEM_RDY = 1'b0; MEM_RDATA = '0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({BUSY, MEM_RD, TLB_WE, DONE, FAULT} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes got %b expected 00000", {BUSY, MEM_RD, TLB_WE, DONE, FAULT});
        end
        checks++;
        if (TLB_ENTRY !== '0 || MEM_ADDR !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got entry %h addr %h expected 0", TLB_ENTRY, MEM_ADDR);
        end
        checks++;
        if (int'(TLB_INDEX) !== ways[0]) begin
            errors++;
            $display("FAIL reset_index got %0d expected %0d", TLB_INDEX, ways[0]);
        end
        RESET = 1'b0;
        way_ptr = 0;
        @(posedge CLK); #1;
        checks++;
        if (BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy %b expected 0", BUSY);
        end
    endtask

    task automatic test_basic();
        logic rd_ok, stable, we, dn, ft, bz, bza, pa;
        logic [31:0] addr;
        logic [LOG_WAYS-1:0] idx;
        logic [ENTRY_W-1:0] ent, exp_e;
        PTBR  = 32'h0010_0000;
        exp_e = {22'h000003, 8'h05, 22'h000023, 1'b1, 1'b1};
        do_walk(22'h000003, 8'h05, 32'h0000_8C03, 2, 1'b0, 1'b0,
                rd_ok, addr, stable, we, dn, ft, bz, idx, ent, bza, pa);
        checks++;
        if (!(rd_ok && stable)) begin
            errors++;
            $display("FAIL basic_memrd got rd_ok %b stable %b expected 1 1", rd_ok, stable);
        end
        checks++;
        if (addr !== 32'h0010_000C) begin
            errors++;
            $display("FAIL basic_addr got %h expected 0010000c", addr);
        end
        checks++;
        if ({we, dn, ft, bz} !== 4'b1101) begin
            errors++;
            $display("FAIL basic_pulses got we/done/fault/busy %b expected 1101", {we, dn, ft, bz});
        end
        checks++;
        if (ent !== exp_e) begin
            errors++;
            $display("FAIL basic_entry got %h expected %h", ent, exp_e);
        end
        checks++;
        if (int'(idx) !== ways[way_ptr]) begin
            errors++;
            $display("FAIL basic_index got %0d expected %0d", idx, ways[way_ptr]);
        end
        way_ptr = (way_ptr + 1) % ways.size();
        checks++;
        if (bza !== 1'b0 || pa !== 1'b0) begin
            errors++;
            $display("FAIL basic_after got busy %b pulses %b expected 0 0", bza, pa);
        end
    endtask

    task automatic test_fault();
        logic rd_ok, stable, we, dn, ft, bz, bza, pa;
        logic [31:0] addr;
        logic [LOG_WAYS-1:0] idx;
        logic [ENTRY_W-1:0] ent;
        PTBR = $urandom;
        do_walk(VPN_W'($urandom), 8'($urandom), 32'h0000_8C02, 1, 1'b0, 1'b0,
                rd_ok, addr, stable, we, dn, ft, bz, idx, ent, bza, pa);
        checks++;
        if ({we, dn, ft, bz} !== 4'b0011) begin
            errors++;
            $display("FAIL fault_pulses got we/done/fault/busy %b expected 0011", {we, dn, ft, bz});
        end
        checks++;
        if (bza !== 1'b0 || pa !== 1'b0) begin
            errors++;
            $display("FAIL fault_after got busy %b pulses %b expected 0 0", bza, pa);
        end
        // The following valid refill must reuse the index a fault did not consume.
        do_walk(VPN_W'($urandom), 8'($urandom), 32'h1234_5401, 0, 1'b0, 1'b0,
                rd_ok, addr, stable, we, dn, ft, bz, idx, ent, bza, pa);
        checks++;
        if (we !== 1'b1 || int'(idx) !== ways[way_ptr]) begin
            errors++;
            $display("FAIL fault_next_index got we %b index %0d expected 1 %0d", we, idx, ways[way_ptr]);
        end
        way_ptr = (way_ptr + 1) % ways.size();
    endtask

    task automatic test_abort();
        logic rd_ok, stable, we, dn, ft, bz, bza, pa;
        logic [31:0] addr;
        logic [LOG_WAYS-1:0] idx;
        logic [ENTRY_W-1:0] ent;
        PTBR = $urandom;
        do_walk(VPN_W'($urandom), 8'($urandom), 32'h0000_8C03, 1, 1'b1, 1'b0,
                rd_ok, addr, stable, we, dn, ft, bz, idx, ent, bza, pa);
        checks++;
        if ({we, dn, ft, bz} !== 4'b0000) begin
            errors++;
            $display("FAIL abort_rdy got we/done/fault/busy %b expected 0000", {we, dn, ft, bz});
        end
        // ABORT while already in FILL does not cancel the write.
        do_walk(VPN_W'($urandom), 8'($urandom), 32'h0000_8C01, 0, 1'b0, 1'b1,
                rd_ok, addr, stable, we, dn, ft, bz, idx, ent, bza, pa);
        checks++;
        if ({we, dn} !== 2'b11 || int'(idx) !== ways[way_ptr]) begin
            errors++;
            $display("FAIL abort_in_fill got we/done %b index %0d expected 11 %0d", {we, dn}, idx, ways[way_ptr]);
        end
        way_ptr = (way_ptr + 1) % ways.size();
    endtask

    task automatic test_five_refills();
        logic rd_ok, stable, we, dn, ft, bz, bza, pa;
        logic [31:0] addr;
        logic [LOG_WAYS-1:0] idx;
        logic [ENTRY_W-1:0] ent;
        int seq[5];
`ifdef WALKER_WIRED_EN
        seq = '{1, 2, 3, 1, 2};
`else
        seq = '{0, 1, 2, 3, 0};
`endif
        pulse_reset();
        for (int k = 0; k < 5; k++) begin
            do_walk(VPN_W'($urandom), 8'($urandom), ($urandom | 32'h1), 0, 1'b0, 1'b0,
                    rd_ok, addr, stable, we, dn, ft, bz, idx, ent, bza, pa);
            checks++;
            if (we !== 1'b1 || int'(idx) !== seq[k]) begin
                errors++;
                $display("FAIL five_index[%0d] got we %b index %0d expected 1 %0d", k, we, idx, seq[k]);
            end
            way_ptr = (way_ptr + 1) % ways.size();
        end
    endtask

    task automatic test_reset_mid_walk();
        MISS_REQ = 1'b1;
        MISS_VPN = VPN_W'($urandom);
        @(posedge CLK); #1;
        MISS_REQ = 1'b0;
        checks++;
        if (MEM_RD !== 1'b1) begin
            errors++;
            $display("FAIL midrst_started got mem_rd %b expected 1", MEM_RD);
        end
        RESET = 1'b1;
        #1;
        checks++;
        if ({BUSY, MEM_RD, TLB_WE, DONE, FAULT} !== 5'b0 || TLB_ENTRY !== '0 ||
            int'(TLB_INDEX) !== ways[0]) begin
            errors++;
            $display("FAIL midrst_async got strobes %b entry %h index %0d expected 00000 0 %0d",
                     {BUSY, MEM_RD, TLB_WE, DONE, FAULT}, TLB_ENTRY, TLB_INDEX, ways[0]);
        end
        @(posedge CLK); #1;
        RESET = 1'b0;
        way_ptr = 0;
        MEM_RDY = 1'b1;
        MEM_RDATA = 32'h0000_8C03;
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK); #1;
            checks++;
            if ({BUSY, MEM_RD, TLB_WE, DONE, FAULT} !== 5'b0 || int'(TLB_INDEX) !== ways[0]) begin
                errors++;
                $display("FAIL midrst_stray[%0d] got strobes %b index %0d expected 00000 %0d",
                         c, {BUSY, MEM_RD, TLB_WE, DONE, FAULT}, TLB_INDEX, ways[0]);
            end
        end
        MEM_RDY = 1'b0;
    endtask

    task automatic test_held_miss();
        int we_count = 0;
        logic exp_rd, exp_we, exp_busy;
        PTBR = $urandom;
        MISS_REQ = 1'b1;
        MISS_VPN = VPN_W'($urandom);
        MEM_RDY = 1'b1;
        MEM_RDATA = 32'hABCD_E401;
        // Each walk: READ (accepted at once), FILL, one IDLE cycle, then restart.
        for (int c = 0; c < 9; c++) begin
            @(posedge CLK); #1;
            exp_rd   = (c % 3 == 0);
            exp_we   = (c % 3 == 1);
            exp_busy = (c % 3 != 2);
            if (TLB_WE === 1'b1) we_count++;
            checks++;
            if (MEM_RD !== exp_rd || TLB_WE !== exp_we || DONE !== exp_we || BUSY !== exp_busy) begin
                errors++;
                $display("FAIL held_cycle[%0d] got rd/we/done/busy %b%b%b%b expected %b%b%b%b",
                         c, MEM_RD, TLB_WE, DONE, BUSY, exp_rd, exp_we, exp_we, exp_busy);
            end
            if (exp_we) begin
                checks++;
                if (int'(TLB_INDEX) !== ways[way_ptr]) begin
                    errors++;
                    $display("FAIL held_index[%0d] got %0d expected %0d", c, TLB_INDEX, ways[way_ptr]);
                end
                way_ptr = (way_ptr + 1) % ways.size();
            end
        end
        MISS_REQ = 1'b0;
        MEM_RDY = 1'b0;
        checks++;
        if (we_count != 3) begin
            errors++;
            $display("FAIL held_count got %0d expected 3", we_count);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_random_walks();
        logic rd_ok, stable, we, dn, ft, bz, bza, pa;
        logic [31:0] addr, rdata, exp_addr;
        logic [LOG_WAYS-1:0] idx;
        logic [ENTRY_W-1:0] ent, exp_e;
        logic [VPN_W-1:0] vpn;
        logic [7:0] asid;
        logic ab_rdy, ab_fill, valid;
        int wait_n;
        for (int t = 0; t < 24; t++) begin
            PTBR    = $urandom;
            vpn     = VPN_W'($urandom);
            asid    = 8'($urandom);
            rdata   = $urandom;
            valid   = ($urandom_range(3, 0) != 0);
            rdata[0] = valid;
            wait_n  = $urandom_range(3, 0);
            ab_rdy  = ($urandom_range(5, 0) == 0);
            ab_fill = ($urandom_range(5, 0) == 0);
            exp_addr = PTBR + 32'(vpn) * 32'd4;
            if (!ab_rdy && valid)
                exp_q.push_back({vpn, asid, PFN_W'(rdata >> 10), rdata[1], 1'b1});
            do_walk(vpn, asid, rdata, wait_n, ab_rdy, ab_fill,
                    rd_ok, addr, stable, we, dn, ft, bz, idx, ent, bza, pa);
            checks++;
            if (!(rd_ok && stable) || addr !== exp_addr) begin
                errors++;
                $display("FAIL rand_read[%0d] got rd_ok %b stable %b addr %h expected 1 1 %h",
                         t, rd_ok, stable, addr, exp_addr);
            end
            if (ab_rdy) begin
                checks++;
                if ({we, dn, ft, bz} !== 4'b0000) begin
                    errors++;
                    $display("FAIL rand_abort[%0d] got we/done/fault/busy %b expected 0000", t, {we, dn, ft, bz});
                end
            end else if (!valid) begin
                checks++;
                if ({we, dn, ft, bz} !== 4'b0011) begin
                    errors++;
                    $display("FAIL rand_fault[%0d] got we/done/fault/busy %b expected 0011", t, {we, dn, ft, bz});
                end
            end else begin
                exp_e = exp_q.pop_front();
                checks++;
                if ({we, dn, ft, bz} !== 4'b1101 || int'(idx) !== ways[way_ptr]) begin
                    errors++;
                    $display("FAIL rand_fill[%0d] got we/done/fault/busy %b index %0d expected 1101 %0d",
                             t, {we, dn, ft, bz}, idx, ways[way_ptr]);
                end
                checks++;
                if (ent !== exp_e) begin
                    errors++;
                    $display("FAIL rand_entry[%0d] got %h expected %h", t, ent, exp_e);
                end
                way_ptr = (way_ptr + 1) % ways.size();
            end
            checks++;
            if (bza !== 1'b0 || pa !== 1'b0) begin
                errors++;
                $display("FAIL rand_after[%0d] got busy %b pulses %b expected 0 0", t, bza, pa);
            end
        end
    endtask

    initial begin
`ifdef WALKER_WIRED_EN
        for (int w = 1; w < (1 << LOG_WAYS); w++) ways.push_back(w);
`else
        for (int w = 0; w < (1 << LOG_WAYS); w++) ways.push_back(w);
`endif
        way_ptr = 0;
        test_reset();
        test_basic();
        test_fault();
        test_abort();
        test_five_refills();
        test_reset_mid_walk();
        test_held_miss();
        test_random_walks();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
